// File: rtl/id_stage_pipe.sv
// RV32I decode stage: operand forwarding, immediate generation, load-use stalls and an ID/EX
// output register. Define ID_ILLEGAL_CHK_EN to enable illegal-instruction detection on illegal_o.
module id_stage_pipe #(
  parameter int XLEN    = 32,
  parameter int NUM_FWD = 2,
  parameter int CNT_W   = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    flush_i,
  input  logic                    in_valid_i,
  output logic                    in_ready_o,
  input  logic [31:0]             inst_i,
  input  logic [XLEN-1:0]         instaddr_i,
  output logic [4:0]              rs1_addr_o,
  output logic [4:0]              rs2_addr_o,
  output logic                    rs1_read_o,
  output logic                    rs2_read_o,
  input  logic [XLEN-1:0]         rs1_data_i,
  input  logic [XLEN-1:0]         rs2_data_i,
  input  logic [NUM_FWD-1:0]      fwd_wen_i,
  input  logic [5*NUM_FWD-1:0]    fwd_addr_i,
  input  logic [XLEN*NUM_FWD-1:0] fwd_data_i,
  input  logic                    ex_load_i,
  input  logic [4:0]              ex_rd_i,
  output logic                    out_valid_o,
  input  logic                    out_ready_i,
  output logic [31:0]             inst_o,
  output logic [XLEN-1:0]         instaddr_o,
  output logic [XLEN-1:0]         op1_o,
  output logic [XLEN-1:0]         op2_o,
  output logic [XLEN-1:0]         imm_o,
  output logic [XLEN-1:0]         src_o,
  output logic [4:0]              rd_addr_o,
  output logic                    regs_wen_o,
  output logic [CNT_W-1:0]        stall_cnt_o,
  output logic                    illegal_o
);

  localparam logic [6:0] OP_IMM    = 7'h13;
  localparam logic [6:0] OP_REG    = 7'h33;
  localparam logic [6:0] OP_LOAD   = 7'h03;
  localparam logic [6:0] OP_STORE  = 7'h23;
  localparam logic [6:0] OP_BRANCH = 7'h63;
  localparam logic [6:0] OP_JAL    = 7'h6F;
  localparam logic [6:0] OP_JALR   = 7'h67;
  localparam logic [6:0] OP_LUI    = 7'h37;
  localparam logic [6:0] OP_AUIPC  = 7'h17;

  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  logic [XLEN-1:0] rs1_val, rs2_val;
  logic            rs1_hit, rs2_hit;
  logic [XLEN-1:0] d_op1, d_op2, d_imm, d_src;
  logic            d_wen, d_ill, wen_final, hazard;

  assign opcode     = inst_i[6:0];
  assign funct3     = inst_i[14:12];
  assign rs1_addr_o = inst_i[19:15];
  assign rs2_addr_o = inst_i[24:20];

  assign imm_i = XLEN'($signed(inst_i[31:20]));
  assign imm_s = XLEN'($signed({inst_i[31:25], inst_i[11:7]}));
  assign imm_b = XLEN'($signed({inst_i[31], inst_i[7], inst_i[30:25], inst_i[11:8], 1'b0}));
  assign imm_u = XLEN'($signed({inst_i[31:12], 12'b0}));
  assign imm_j = XLEN'($signed({inst_i[31], inst_i[19:12], inst_i[20], inst_i[30:21], 1'b0}));

  // Lowest-index matching source wins; x0 is hard-wired to zero regardless of forwarding.
  always_comb begin
    rs1_val = rs1_data_i;
    rs2_val = rs2_data_i;
    rs1_hit = 1'b0;
    rs2_hit = 1'b0;
    for (int k = 0; k < NUM_FWD; k++) begin
      if (!rs1_hit && fwd_wen_i[k] && fwd_addr_i[5*k +: 5] == rs1_addr_o) begin
        rs1_val = fwd_data_i[XLEN*k +: XLEN];
        rs1_hit = 1'b1;
      end
      if (!rs2_hit && fwd_wen_i[k] && fwd_addr_i[5*k +: 5] == rs2_addr_o) begin
        rs2_val = fwd_data_i[XLEN*k +: XLEN];
        rs2_hit = 1'b1;
      end
    end
    if (rs1_addr_o == 5'd0) rs1_val = '0;
    if (rs2_addr_o == 5'd0) rs2_val = '0;
  end

  always_comb begin
    rs1_read_o = 1'b0;
    rs2_read_o = 1'b0;
    d_op1      = '0;
    d_op2      = '0;
    d_imm      = '0;
    d_src      = '0;
    d_wen      = 1'b0;
    case (opcode)
      OP_IMM: begin
        rs1_read_o = 1'b1;
        d_op1      = rs1_val;
        d_imm      = imm_i;
        d_op2      = (funct3 == 3'b001 || funct3 == 3'b101) ? XLEN'(inst_i[24:20]) : imm_i;
        d_wen      = 1'b1;
      end
      OP_REG: begin
        rs1_read_o = 1'b1;
        rs2_read_o = 1'b1;
        d_op1      = rs1_val;
        d_op2      = rs2_val;
        d_wen      = 1'b1;
      end
      OP_LOAD: begin
        rs1_read_o = 1'b1;
        d_op1      = rs1_val;
        d_op2      = imm_i;
        d_imm      = imm_i;
        d_wen      = 1'b1;
      end
      OP_STORE: begin
        rs1_read_o = 1'b1;
        rs2_read_o = 1'b1;
        d_op1      = rs1_val;
        d_op2      = imm_s;
        d_imm      = imm_s;
        d_src      = rs2_val;
      end
      OP_BRANCH: begin
        rs1_read_o = 1'b1;
        rs2_read_o = 1'b1;
        d_op1      = rs1_val;
        d_op2      = rs2_val;
        d_imm      = imm_b;
      end
      OP_JAL: begin
        d_op1 = instaddr_i;
        d_op2 = XLEN'(32'd4);
        d_imm = imm_j;
        d_wen = 1'b1;
      end
      OP_JALR: begin
        rs1_read_o = 1'b1;
        d_op1      = instaddr_i;
        d_op2      = XLEN'(32'd4);
        d_imm      = imm_i;
        d_src      = rs1_val;
        d_wen      = 1'b1;
      end
      OP_LUI: begin
        d_op1 = imm_u;
        d_imm = imm_u;
        d_wen = 1'b1;
      end
      OP_AUIPC: begin
        d_op1 = instaddr_i;
        d_op2 = imm_u;
        d_imm = imm_u;
        d_wen = 1'b1;
      end
      default: ;
    endcase
  end

`ifdef ID_ILLEGAL_CHK_EN
  logic [6:0] funct7;
  assign funct7 = inst_i[31:25];

  always_comb begin
    d_ill = 1'b0;
    case (opcode)
      OP_IMM:
        if ((funct3 == 3'b001 && funct7 != 7'h00) ||
            (funct3 == 3'b101 && funct7 != 7'h00 && funct7 != 7'h20)) d_ill = 1'b1;
      OP_REG:
        if (!(funct7 == 7'h00 ||
              (funct7 == 7'h20 && (funct3 == 3'b000 || funct3 == 3'b101)))) d_ill = 1'b1;
      OP_LOAD:
        if (funct3 == 3'b011 || funct3 == 3'b110 || funct3 == 3'b111) d_ill = 1'b1;
      OP_STORE:
        if (funct3 > 3'b010) d_ill = 1'b1;
      OP_BRANCH:
        if (funct3 == 3'b010 || funct3 == 3'b011) d_ill = 1'b1;
      OP_JALR:
        if (funct3 != 3'b000) d_ill = 1'b1;
      OP_JAL, OP_LUI, OP_AUIPC: ;
      default: d_ill = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) illegal_o <= 1'b0;
    else if (!flush_i && in_valid_i && in_ready_o) illegal_o <= d_ill;
  end
`else
  assign d_ill     = 1'b0;
  assign illegal_o = 1'b0;
`endif

  assign wen_final = d_wen & ~d_ill;

  assign hazard = ex_load_i && (ex_rd_i != 5'd0) &&
                  ((rs1_read_o && rs1_addr_o == ex_rd_i) || (rs2_read_o && rs2_addr_o == ex_rd_i));

  // Handshake: a transfer happens on an edge where valid and ready are both high; the ID/EX
  // register holds every field while out_valid_o is high and out_ready_i is low.
  assign in_ready_o = (!out_valid_o || out_ready_i) && !hazard && !flush_i;

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_o <= 1'b0;
      inst_o      <= '0;
      instaddr_o  <= '0;
      op1_o       <= '0;
      op2_o       <= '0;
      imm_o       <= '0;
      src_o       <= '0;
      rd_addr_o   <= '0;
      regs_wen_o  <= 1'b0;
    end else if (flush_i) begin
      out_valid_o <= 1'b0;
    end else if (in_valid_i && in_ready_o) begin
      out_valid_o <= 1'b1;
      inst_o      <= inst_i;
      instaddr_o  <= instaddr_i;
      op1_o       <= d_op1;
      op2_o       <= d_op2;
      imm_o       <= d_imm;
      src_o       <= d_src;
      rd_addr_o   <= wen_final ? inst_i[11:7] : 5'd0;
      regs_wen_o  <= wen_final;
    end else if (out_ready_i) begin
      out_valid_o <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) stall_cnt_o <= '0;
    else if (in_valid_i && hazard && stall_cnt_o != '1) stall_cnt_o <= stall_cnt_o + CNT_W'(1);
  end

endmodule
